// File: rtl/iter_shift_unit.sv
// Multi-cycle RV32 shift unit (SLL/SRL/SRA) moving up to STEP bits per cycle.
// Optional rotate-right on op=10 when ISU_ROTATE_EN is defined; otherwise op=10 runs as SRL.
module iter_shift_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               op,
  input  logic [XLEN-1:0]          a,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          result,
  output logic                     busy
);

  localparam int unsigned SW = $clog2(XLEN);
  // One extra bit so STEP == XLEN is representable.
  localparam int unsigned AW = SW + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b11;
`ifdef ISU_ROTATE_EN
  localparam logic [1:0] OP_ROR = 2'b10;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic              sign_q;
  logic [XLEN-1:0]   acc;
  logic [SW-1:0]     rem;

  logic [AW-1:0]     amt;
  logic [SW-1:0]     rem_nxt;
  logic              fill;
  logic [2*XLEN-1:0] ext;
  logic [XLEN-1:0]   shr;
  logic [XLEN-1:0]   shifted;

  // Per-cycle step: amt = min(rem, STEP), then one small shift of acc.
  always_comb begin
    amt     = AW'(STEP);
    if ({1'b0, rem} < AW'(STEP)) begin
      amt = {1'b0, rem};
    end
    rem_nxt = rem - SW'(amt);
    fill    = (op_q == OP_SRA) && sign_q;
    ext     = {{XLEN{fill}}, acc};
`ifdef ISU_ROTATE_EN
    if (op_q == OP_ROR) begin
      ext = {acc, acc};
    end
`endif
    shr     = XLEN'(ext >> amt);
    shifted = shr;
    if (op_q == OP_SLL) begin
      shifted = acc << amt;
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= 2'b00;
      sign_q    <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            sign_q   <= a[XLEN-1];
            acc      <= a;
            rem      <= shamt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (shamt == '0) begin
              result    <= a;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          acc <= shifted;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            result    <= shifted;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          // Return to IDLE only; the next request is taken a cycle later.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit (XLEN=32, STEP=4).
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRA = 2'b11;

  iter_shift_unit #(.XLEN(32), .STEP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue one op from IDLE, scramble inputs after accept, return result and
  // number of edges from accept until out_valid is seen (sampled on negedge).
  task automatic run_op(input logic [1:0] o, input logic [31:0] av,
                        input logic [4:0] sv, output logic [31:0] res,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = av; shamt = sv;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = ~o; a = ~av; shamt = ~sv;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 32'h0) begin
      failures++;
      $display("FAIL reset: ov=%b ir=%b busy=%b res=%h, want 0 1 0 00000000",
               out_valid, in_ready, busy, result);
    end
  endtask

  task automatic test_vector(input string name, input logic [1:0] o,
                             input logic [31:0] av, input logic [4:0] sv,
                             input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int lat;
    run_op(o, av, sv, res, lat);
    checks++;
    if (res !== exp_res) begin
      failures++;
      $display("FAIL %s result: got %h want %h", name, res, exp_res);
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s done_flags: ir=%b busy=%b want 0 1", name, in_ready, busy);
    end
    // out_ready is high: transfer at next edge, then IDLE.
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release: ov=%b ir=%b busy=%b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    out_ready = 1'b0;
    run_op(SRL, 32'hF000_0000, 5'd4, res, lat);
    checks++;
    if (res !== 32'h0F00_0000 || lat !== 1) begin
      failures++;
      $display("FAIL bp_first: res=%h lat=%0d want 0f000000 1", res, lat);
    end
    in_valid = 1'b1; op = SLL; a = 32'h1234_5678; shamt = 5'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (result !== 32'h0F00_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: res=%h ov=%b ir=%b want 0f000000 1 0",
                 i, result, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    run_op(SLL, 32'h0000_00FF, 5'd8, res, lat);
    checks++;
    if (res !== 32'h0000_FF00) begin
      failures++;
      $display("FAIL b2b_first: got %h want 0000ff00", res);
    end
    // Request held across DONE must not be taken until IDLE.
    in_valid = 1'b1; op = SRA; a = 32'h8000_0000; shamt = 5'd4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: ir=%b busy=%b want 0 1", in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || result !== 32'hF800_0000) begin
      failures++;
      $display("FAIL b2b_second: ov=%b res=%h want 1 f8000000", out_valid, result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    in_valid = 1'b1; op = SRL; a = 32'hFFFF_FFFF; shamt = 5'd20;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: ov=%b res=%h ir=%b busy=%b want 0 00000000 1 0",
               out_valid, result, in_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = SLL; a = '0; shamt = '0; out_ready = 1'b1;
    #2;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_vector("sra_small", SRA, 32'h0000_0010, 5'd1,  32'h0000_0008, 1);
    test_vector("sra_neg2",  SRA, 32'hFFFF_FFEC, 5'd2,  32'hFFFF_FFFB, 1);
    test_vector("sra_max",   SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 8);
    test_vector("sll_max",   SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 8);
    test_vector("srl_28",    SRL, 32'h8000_0000, 5'd28, 32'h0000_0008, 7);
    test_vector("zero_amt",  SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 0);
    test_vector("sll_8",     SLL, 32'h1234_5678, 5'd8,  32'h3456_7800, 2);
    test_vector("sra_pos",   SRA, 32'h7FFF_FFFF, 5'd5,  32'h03FF_FFFF, 2);
    test_vector("srl_5",     SRL, 32'hF000_000F, 5'd5,  32'h0780_0000, 2);
`ifdef ISU_ROTATE_EN
    test_vector("ror_1",     ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1);
    test_vector("ror_12",    ROR, 32'h1234_5678, 5'd12, 32'h6781_2345, 3);
`else
    test_vector("op10_1",    ROR, 32'h0000_0001, 5'd1,  32'h0000_0000, 1);
    test_vector("op10_12",   ROR, 32'h8234_5678, 5'd12, 32'h0008_2345, 3);
`endif
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    test_vector("after_rst", SRL, 32'hA000_0000, 5'd3,  32'h1400_0000, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
